engine_scheduler: RTL
=====================

ENGINE_SCHEDULER -- requirements
Module: engine_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_ENGINES, default 4, meaning the number of Mandelbrot engine slots scheduled.
REQ-002 The block SHALL have parameter X_SIZE, default 640, meaning the pixels per line.
REQ-003 The block SHALL have parameter Y_SIZE, default 480, meaning the lines per frame.
REQ-004 The block SHALL have parameter DEPTH_W, default 10, meaning the escape-depth width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: out_stream_aclk  in  1  clock.
REQ-006 periph_resetn  in  1  asynchronous active-low reset.
REQ-007 line_start  in  1  one-cycle request to compute the next line.
REQ-008 line_busy  out  1  high from an accepted line_start until line_done.
REQ-009 line_done  out  1  one-cycle pulse when all X_SIZE results of the line are written.
REQ-010 y_out  out  9  index of the line being computed.
REQ-011 eng_start  out  NUM_ENGINES  per-engine one-cycle start pulse.
REQ-012 eng_x  out  NUM_ENGINES*10  per-engine pixel x, valid with eng_start and held until the next start.
REQ-013 eng_done  in  NUM_ENGINES  per-engine result valid, held until eng_ack.
REQ-014 eng_depth  in  NUM_ENGINES*DEPTH_W  per-engine escape depth, valid with eng_done.
REQ-015 eng_ack  out  NUM_ENGINES  per-engine one-cycle result acknowledge.
REQ-016 wr_en, wr_addr[9:0], wr_data[DEPTH_W-1:0]  out  line-buffer write port.

Function
REQ-017 The FSM SHALL have states IDLE, DISPATCH, DRAIN, and DONE.
REQ-018 IDLE->DISPATCH on line_start; next_x and wr_count SHALL clear to 0 on that transition.
REQ-019 line_start in any state other than IDLE SHALL be ignored.
REQ-020 The block SHALL track a busy flag per slot, set on eng_start and cleared on eng_ack.
REQ-021 In DISPATCH, at most one start SHALL issue per cycle, to the lowest-index non-busy slot.
REQ-022 Each start SHALL put eng_x = next_x for that slot and increment next_x.
REQ-023 A slot acked in cycle N SHALL NOT be restarted before cycle N+1.
REQ-024 DISPATCH->DRAIN in the cycle the start with next_x = X_SIZE-1 issues.
REQ-025 In DISPATCH and DRAIN, at most one result SHALL be accepted per cycle, chosen round-robin.
REQ-026 The round-robin search SHALL start at the slot after the last acked slot; its pointer resets to slot 0.
REQ-027 An accepted result SHALL produce, in the same cycle: eng_ack[i]=1, wr_en=1, wr_addr=latched x of slot i, wr_data=eng_depth[i].
REQ-028 Each accepted result SHALL increment wr_count.
REQ-029 Dispatch and collection SHALL proceed concurrently in the same cycle.
REQ-030 DRAIN->DONE in the cycle the X_SIZE-th write occurs.
REQ-031 DONE SHALL pulse line_done for one cycle, then enter IDLE.
REQ-032 On line_done, y_out SHALL increment, wrapping from Y_SIZE-1 to 0.
REQ-033 eng_done on a non-busy slot SHALL be ignored and SHALL NOT be acked.
REQ-034 line_busy SHALL be high exactly in DISPATCH and DRAIN.
REQ-035 Start-to-write latency per pixel SHALL be engine latency + 0 cycles (combinational ack and write).
REQ-036 Arithmetic SHALL be unsigned, with next_x and wr_count each 10 bits wide.

Reset
REQ-037 Asserted reset SHALL force, immediately: state=IDLE, all busy flags=0, next_x=0, wr_count=0, y_out=0, rr pointer=0.
REQ-038 Asserted reset SHALL force eng_start, eng_ack, wr_en, line_done, and line_busy to 0, and eng_x to 0.
REQ-039 Reset mid-line SHALL abandon the line; results arriving afterwards SHALL be ignored.

Structure
REQ-040 X_SIZE, Y_SIZE, DEPTH_W, and state encodings SHALL reside in the shared mandelbrot_pkg.
REQ-041 One sub-module, rr_arbiter (NUM_ENGINES request, one-hot grant, rotating pointer), SHALL implement the collection arbitration.

Verification
REQ-042 Reset mid-line: at next_x=100 -> all outputs 0, and a later eng_done is not acked.
REQ-043 Single line, fixed engine latency of 5 cycles, NUM_ENGINES=4 -> 640 writes with addresses 0..639 each once, one line_done, and y_out changes 0->1.
REQ-044 Simultaneous eng_done on slots 0..3 -> acks issue in order 0,1,2,3 on consecutive cycles, and wr_addr matches each slot's eng_x.
REQ-045 Random latencies of 1..50 cycles over 3 lines -> every address written exactly once per line, and no start is issued to a busy slot.
REQ-046 line_start pulsed during DRAIN -> ignored, and line_busy stays high until the single line_done.
REQ-047 480 lines -> y_out wraps from 479 to 0 on the 480th line_done.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared frame geometry, result width and line-scheduler state encoding
// for the Mandelbrot renderer.
package mandelbrot_pkg;

  localparam int X_SIZE  = 640;
  localparam int Y_SIZE  = 480;
  localparam int DEPTH_W = 10;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, with the search starting one slot past
// the most recently granted requester.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         grant_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] grant_idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    grant_idx     = '0;
    sel           = '0;
    for (int i = 0; i < N; i++) begin
      sel = IDX_W'((int'(ptr_q) + i) % N);
      if (!grant_valid_o && req_i[sel]) begin
        grant_valid_o  = 1'b1;
        grant_o[sel]   = 1'b1;
        grant_idx      = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid_o) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/engine_scheduler.sv
// Hands out the pixels of one line to a pool of Mandelbrot engines and
// collects their escape depths into the line buffer.
//
//   state    | meaning
//   IDLE     | waiting for line_start
//   DISPATCH | issuing pixels to free engines, collecting results
//   DRAIN    | every pixel issued, collecting the remaining results
//   DONE     | one-cycle line_done, advance y_out
module engine_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = mandelbrot_pkg::X_SIZE,
  parameter int Y_SIZE      = mandelbrot_pkg::Y_SIZE,
  parameter int DEPTH_W     = mandelbrot_pkg::DEPTH_W
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_resetn,
  input  logic                           line_start,
  output logic                           line_busy,
  output logic                           line_done,
  output logic [8:0]                     y_out,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [NUM_ENGINES*10-1:0]      eng_x,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic [NUM_ENGINES-1:0]         eng_ack,
  output logic                           wr_en,
  output logic [9:0]                     wr_addr,
  output logic [DEPTH_W-1:0]             wr_data
);
  import mandelbrot_pkg::*;

  sched_state_e                       state_q, state_d;
  logic [NUM_ENGINES-1:0]             busy_q, busy_d;
  logic [NUM_ENGINES-1:0][X_W-1:0]    slot_x_q, slot_x_d;
  logic [X_W-1:0]                     next_x_q, next_x_d;
  logic [X_W-1:0]                     wr_count_q, wr_count_d;
  logic [Y_W-1:0]                     y_q, y_d;
  logic [NUM_ENGINES-1:0]             req, grant;
  logic                               grant_valid;
  logic                               collect;
  logic                               start_found;

  // A result only counts while its slot is actually outstanding.
  assign collect = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
  assign req     = eng_done & busy_q & {NUM_ENGINES{collect}};

  rr_arbiter #(.N(NUM_ENGINES)) u_rr (
    .clk_i         (out_stream_aclk),
    .rst_ni        (periph_resetn),
    .req_i         (req),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    slot_x_d    = slot_x_q;
    next_x_d    = next_x_q;
    wr_count_d  = wr_count_q;
    y_d         = y_q;
    eng_start   = '0;
    eng_ack     = grant;
    wr_en       = grant_valid;
    wr_addr     = '0;
    wr_data     = '0;
    line_done   = 1'b0;
    line_busy   = 1'b0;
    start_found = 1'b0;

    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (grant[i]) begin
        wr_addr = slot_x_q[i];
        wr_data = eng_depth[i*DEPTH_W +: DEPTH_W];
      end
    end
    if (grant_valid) begin
      busy_d     = busy_q & ~grant;
      wr_count_d = wr_count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          next_x_d   = '0;
          wr_count_d = '0;
          state_d    = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        line_busy = 1'b1;
        // Dispatch looks at registered busy, so a slot acked this cycle waits.
        for (int i = 0; i < NUM_ENGINES; i++) begin
          if (!start_found && !busy_q[i]) begin
            start_found  = 1'b1;
            eng_start[i] = 1'b1;
            slot_x_d[i]  = next_x_q;
            busy_d[i]    = 1'b1;
          end
        end
        if (start_found) begin
          next_x_d = next_x_q + 1'b1;
          if (next_x_q == X_W'(X_SIZE - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        line_busy = 1'b1;
        if (grant_valid && wr_count_q == X_W'(X_SIZE - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        line_done = 1'b1;
        y_d       = (y_q == Y_W'(Y_SIZE - 1)) ? '0 : y_q + 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign eng_x = slot_x_d;
  assign y_out = y_q;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      slot_x_q   <= '0;
      next_x_q   <= '0;
      wr_count_q <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      slot_x_q   <= slot_x_d;
      next_x_q   <= next_x_d;
      wr_count_q <= wr_count_d;
      y_q        <= y_d;
    end
  end

endmodule
